// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM encoding,
// command constants and the frame parity helper.
package ps2_host_tx_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INHIBIT = 3'd1,
      S_REQ     = 3'd2,
      S_DATA    = 3'd3,
      S_PARITY  = 3'd4,
      S_STOP    = 3'd5,
      S_WAIT_HI = 3'd6,
      S_FIN     = 3'd7
   } state_e;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
   localparam int unsigned PS2_FRAME_LEN  = 11;

   function automatic logic odd_par(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and status bundle between the system and
// the PS/2 host transmitter.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, busy, done, err
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, busy, done, err
   );
endinterface

// File: rtl/ps2_host_tx_line_sync.sv
// 3-flop synchronizers for the raw PS/2 clock and data lines plus a
// falling-edge pulse on the synchronized clock.
module ps2_host_tx_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic clk_s_o,
   output logic data_s_o,
   output logic fall_o
);

   logic [2:0] clk_sync_q;
   logic [2:0] data_sync_q;

   // Idle bus is high; resetting to 1 avoids a spurious edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync_q  <= 3'b111;
         data_sync_q <= 3'b111;
      end else begin
         clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
         data_sync_q <= {data_sync_q[1:0], ps2_data_i};
      end
   end

   assign fall_o   = clk_sync_q[2] & ~clk_sync_q[1];
   assign clk_s_o  = clk_sync_q[2];
   assign data_s_o = data_sync_q[2];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter (request-to-send, open-drain enables).
// Define PS2_TX_TIMEOUT_EN to add a per-transfer watchdog.
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic          clk,
   input  logic          rst,
   ps2_host_tx_if.slave  tx_if,
   input  logic          ps2_clk_i,
   input  logic          ps2_data_i,
   output logic          ps2_clk_oe_o,
   output logic          ps2_data_oe_o
);

   localparam int unsigned ICW =
      (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam logic [ICW-1:0] ILAST = ICW'(INHIBIT_CYCLES - 1);

   state_e     state_q, state_d;
   logic [ICW-1:0] icnt_q, icnt_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic [7:0] shreg_q, shreg_d;
   logic       par_q, par_d;
   logic       nack_q, nack_d;
   logic       clk_oe_q, clk_oe_d;
   logic       data_oe_q, data_oe_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       ready_q, busy_q;
   logic       clk_s, data_s, fall;

`ifdef PS2_TX_TIMEOUT_EN
   localparam int unsigned TCW =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TCW-1:0] TLAST = TCW'(TIMEOUT_CYCLES - 1);
   logic [TCW-1:0] tmo_q, tmo_d;
`endif

   ps2_host_tx_line_sync u_sync (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk_i  (ps2_clk_i),
      .ps2_data_i (ps2_data_i),
      .clk_s_o    (clk_s),
      .data_s_o   (data_s),
      .fall_o     (fall)
   );

   // Outputs are derived from the next state so they come straight off flops.
   always_comb begin
      state_d   = state_q;
      icnt_d    = icnt_q;
      bitcnt_d  = bitcnt_q;
      shreg_d   = shreg_q;
      par_d     = par_q;
      nack_d    = nack_q;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      tmo_d     = '0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (tx_if.tx_valid) begin
               state_d   = S_INHIBIT;
               shreg_d   = tx_if.tx_data;
               par_d     = odd_par(tx_if.tx_data);
               nack_d    = 1'b0;
               icnt_d    = '0;
               clk_oe_d  = 1'b1;
               data_oe_d = (ILAST == '0);
            end
         end
         S_INHIBIT: begin
            clk_oe_d = 1'b1;
            if (icnt_q == ILAST) begin
               state_d   = S_REQ;
               icnt_d    = '0;
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b1;
            end else begin
               icnt_d    = icnt_q + ICW'(1);
               data_oe_d = (icnt_d == ILAST);
            end
         end
         S_REQ: begin
            data_oe_d = 1'b1;
            if (fall) begin
               state_d   = S_DATA;
               bitcnt_d  = 3'd0;
               data_oe_d = ~shreg_q[0];
            end
         end
         S_DATA: begin
            data_oe_d = ~shreg_q[bitcnt_q];
            if (fall) begin
               if (bitcnt_q == 3'd7) begin
                  state_d   = S_PARITY;
                  data_oe_d = ~par_q;
               end else begin
                  bitcnt_d  = bitcnt_q + 3'd1;
                  data_oe_d = ~shreg_q[bitcnt_d];
               end
            end
         end
         S_PARITY: begin
            data_oe_d = ~par_q;
            if (fall) begin
               state_d   = S_STOP;
               data_oe_d = 1'b0;
            end
         end
         S_STOP: begin
            if (fall) begin
               state_d = S_WAIT_HI;
               nack_d  = data_s;
            end
         end
         S_WAIT_HI: begin
            if (clk_s && data_s) begin
               state_d = S_FIN;
               done_d  = 1'b1;
               err_d   = nack_q;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog overrides any edge seen in the same cycle.
      if (state_q inside {S_REQ, S_DATA, S_PARITY, S_STOP, S_WAIT_HI}) begin
         if (tmo_q == TLAST) begin
            state_d   = S_FIN;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b1;
            err_d     = 1'b1;
         end else begin
            tmo_d = tmo_q + TCW'(1);
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         icnt_q    <= '0;
         bitcnt_q  <= 3'd0;
         shreg_q   <= 8'h00;
         par_q     <= 1'b0;
         nack_q    <= 1'b0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         icnt_q    <= icnt_d;
         bitcnt_q  <= bitcnt_d;
         shreg_q   <= shreg_d;
         par_q     <= par_d;
         nack_q    <= nack_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         done_q    <= done_d;
         err_q     <= err_d;
         ready_q   <= (state_d == S_IDLE);
         busy_q    <= (state_d != S_IDLE);
      end
   end

`ifdef PS2_TX_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`endif

   assign tx_if.tx_ready = ready_q;
   assign tx_if.busy     = busy_q;
   assign tx_if.done     = done_q;
   assign tx_if.err      = err_q;
   assign ps2_clk_oe_o   = clk_oe_q;
   assign ps2_data_oe_o  = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a scaled-down PS/2 device model
// on an open-drain bus.
module tb_ps2_host_tx;
   import ps2_host_tx_pkg::*;

   localparam int INH  = 20;
   localparam int TMO  = 1000;
   localparam int HALF = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic dev_clk_low  = 1'b0;
   logic dev_data_low = 1'b0;
   logic clk_oe, data_oe;
   logic ps2_clk_w, ps2_data_w;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign ps2_clk_w  = ~(clk_oe  | dev_clk_low);
   assign ps2_data_w = ~(data_oe | dev_data_low);

   ps2_host_tx_if bus ();

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .tx_if         (bus),
      .ps2_clk_i     (ps2_clk_w),
      .ps2_data_i    (ps2_data_w),
      .ps2_clk_oe_o  (clk_oe),
      .ps2_data_oe_o (data_oe)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [7:0] d, input string tag);
      @(negedge clk);
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h5A;
      check({tag, "_accept"}, {bus.tx_ready, bus.busy, clk_oe}, 3'b011);
   endtask

   task automatic measure_inhibit(output int len, output int both);
      int guard;
      len = 0;
      both = 0;
      guard = 0;
      while (clk_oe && guard < 1000) begin
         len++;
         if (data_oe) both++;
         guard++;
         @(negedge clk);
      end
   endtask

   task automatic dev_run(input int n, input bit ack,
                          output logic [9:0] bits);
      bits = '0;
      for (int e = 1; e <= n; e++) begin
         if (e == 11) dev_data_low = ack;
         repeat (HALF) @(negedge clk);
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge clk);
         dev_clk_low = 1'b0;
         if (e <= 10) bits[e-1] = ps2_data_w;
      end
      dev_data_low = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit seen,
                            output logic errv);
      seen = 1'b0;
      errv = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (bus.done) begin
            seen = 1'b1;
            errv = bus.err;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic do_xfer(input logic [7:0] d, input bit ack,
                          input logic [9:0] exp_bits, input bit exp_err,
                          input string tag);
      int len, both;
      logic [9:0] bits;
      bit seen;
      logic errv;
      issue(d, tag);
      measure_inhibit(len, both);
      check({tag, "_inh_len"}, len, INH);
      check({tag, "_inh_data"}, both, 1);
      check({tag, "_req"}, {clk_oe, data_oe}, 2'b01);
      dev_run(11, ack, bits);
      check({tag, "_frame"}, bits, exp_bits);
      wait_done(200, seen, errv);
      check({tag, "_done"}, seen, 1'b1);
      check({tag, "_err"}, errv, exp_err);
      @(negedge clk);
      check({tag, "_after"},
            {bus.tx_ready, bus.busy, bus.done, clk_oe, data_oe}, 5'b10000);
   endtask

   initial begin : main
      int len, both, n;
      logic [9:0] bits;
      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_hold",
            {bus.tx_ready, bus.busy, bus.done, bus.err, clk_oe, data_oe},
            6'b100000);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_idle",
            {bus.tx_ready, bus.busy, bus.done, bus.err, clk_oe, data_oe},
            6'b100000);

      // {stop, parity, data}: ED has six ones, F4 five, 00 none.
      do_xfer(PS2_CMD_SET_LED, 1'b1, 10'h3ED, 1'b0, "ed");
      do_xfer(8'hF4, 1'b1, 10'h2F4, 1'b0, "f4");
      do_xfer(8'h00, 1'b1, 10'h300, 1'b0, "z0");
      do_xfer(PS2_CMD_SET_LED, 1'b0, 10'h3ED, 1'b1, "nack");

      issue(8'hED, "tmo");
      measure_inhibit(len, both);
      check("tmo_inh_len", len, INH);
`ifdef PS2_TX_TIMEOUT_EN
      n = 0;
      while (!bus.done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("tmo_cycles", n, TMO);
      check("tmo_err", bus.err, 1'b1);
      @(negedge clk);
      check("tmo_release", {bus.tx_ready, clk_oe, data_oe}, 3'b100);
`else
      n = 0;
      repeat (3000) @(negedge clk);
      check("tmo_stuck", {bus.busy, bus.tx_ready, clk_oe, data_oe}, 4'b1001);
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
`endif

      issue(8'hA5, "rst");
      measure_inhibit(len, both);
      dev_run(4, 1'b1, bits);
      check("rst_bits", bits[3:0], 4'h5);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check("rst_async",
               {bus.tx_ready, bus.busy, bus.done, clk_oe, data_oe},
               5'b10000);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_no_done", {bus.done, bus.busy}, 2'b00);
      do_xfer(PS2_CMD_RESET, 1'b1, 10'h3FF, 1'b0, "ff");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
